uart_packet_receiver: RTL and testbench
=======================================

Name: uart_packet_receiver

Overview:
- Receive side of the host link; the counterpart of packet_sender.
- Deserialises 8N1 UART bytes from ftdi_rx and assembles PACKET_SIZE consecutive bytes into one packet word.
- Presents the packet with a one-cycle valid strobe to downstream logic (e.g. FFT input buffer or loopback to packet_sender).
- Discards partial packets on framing error or inter-byte timeout.

Parameters:
- CLKS_PER_BIT, 104, hwclk cycles per UART bit (12 MHz / 115200); must be >= 4.
- PACKET_SIZE, 2, bytes per packet; must be >= 1.
- TIMEOUT_BITS, 20, idle bit periods allowed between bytes of one packet before the partial packet is discarded.

Ports:
- clk  in  1  system clock (hwclk)
- rst  in  1  synchronous reset, active-high
- rxd  in  1  asynchronous serial input, idle high
- packet  out  8*PACKET_SIZE  last complete packet; first received byte in bits [8*PACKET_SIZE-1 -: 8], last byte in [7:0]
- valid  out  1  one-cycle pulse when packet updates
- busy  out  1  high while a byte is being received or a partial packet is pending
- frame_err  out  1  one-cycle pulse on bad stop bit or false start
- timeout  out  1  one-cycle pulse when a partial packet is dropped by timeout

Behaviour:
- Reset: all registered state is cleared on a clk edge with rst=1.
  - packet=0, valid=0, busy=0, frame_err=0, timeout=0.
  - Synchroniser flops=1, FSM=IDLE, byte index=0, timers=0.
  - Reset mid-byte or mid-packet abandons everything; no strobe is issued.
- rxd passes through a 2-flop synchroniser; all logic uses the synchronised value rxs.
  - Input-to-detect latency: 2 cycles.
- Bit timer: counts 0..CLKS_PER_BIT-1 and is reloaded on every state change.
- FSM states and transitions:
  - IDLE: rxs=0 -> START, timer cleared.
  - START: at timer=CLKS_PER_BIT/2-1 (mid start bit), sample rxs.
    - 0 -> DATA, bit index=0.
    - 1 -> false start: frame_err pulse, -> IDLE, partial packet discarded.
  - DATA: every CLKS_PER_BIT cycles (mid-bit), sample rxs into the shift register LSB first; after bit 7 -> STOP.
  - STOP: one CLKS_PER_BIT after the last data sample, sample rxs.
    - 1 -> byte accepted, -> IDLE.
    - 0 -> frame_err pulse, byte index reset to 0, partial packet dropped, -> IDLE.
    - In either case, IDLE is only left again on a fresh falling level (rxs=0).
- Packet assembly:
  - Each accepted byte is written into assembly slot byte_index, then byte_index increments.
  - When byte_index reaches PACKET_SIZE:
    - the assembly register is copied to packet and byte_index wraps to 0;
    - valid=1 on the cycle following the stop-bit sample, for exactly one cycle.
  - packet holds its value until the next complete packet; it is never partially updated.
- Timeout:
  - While in IDLE with byte_index != 0, an idle counter runs.
  - At TIMEOUT_BITS*CLKS_PER_BIT cycles: timeout pulse, byte_index=0.
  - The idle counter clears on any start detection.
- busy = (FSM != IDLE) or (byte_index != 0).
- Simultaneous events: valid and frame_err can never coincide; timeout cannot occur outside IDLE.
- Back-to-back bytes (stop bit followed immediately by a start bit) are accepted with no gap required.

Test Plan (CLKS_PER_BIT=8, PACKET_SIZE=2, TIMEOUT_BITS=4 for sim):
- Send 0x61, 0x62 back-to-back -> single valid pulse; packet=16'h6162; busy falls to 0 the same cycle valid rises; frame_err=0, timeout=0.
- Send 0x61 only, then hold rxd=1 -> no valid; timeout pulse 32 cycles after returning to IDLE; busy=0 afterwards; packet unchanged (0).
- Send 0x55 with stop bit forced 0, then 0x12, 0x34 -> frame_err pulse at the bad stop sample; next valid gives packet=16'h1234.
- Glitch rxd low for 2 cycles while idle -> frame_err pulse (false start); no byte accepted; FSM returns to IDLE.
- Assert rst for 1 cycle mid-way through the second byte of a packet, then send 0xAA, 0x0F -> all outputs 0 after reset; next valid gives packet=16'hAA0F.
- Send four bytes 01 02 03 04 continuously -> two valid pulses with packet=16'h0102, then 16'h0304; packet stable between pulses.

Source files
------------

// File: rtl/uart_packet_receiver_if.sv
// uart_packet_receiver_if: serial input and packet/status outputs of the UART packet receiver
interface uart_packet_receiver_if #(parameter int PACKET_SIZE = 2);
  logic rxd;
  logic [8*PACKET_SIZE-1:0] packet;
  logic valid;
  logic busy;
  logic frame_err;
  logic timeout;
  modport master(output rxd, input packet, valid, busy, frame_err, timeout);
  modport slave(input rxd, output packet, valid, busy, frame_err, timeout);
endinterface

// File: rtl/uart_packet_receiver.sv
// uart_packet_receiver: 8N1 UART deserialiser assembling PACKET_SIZE bytes into one packet word
module uart_packet_receiver #(
  parameter int CLKS_PER_BIT = 104,
  parameter int PACKET_SIZE = 2,
  parameter int TIMEOUT_BITS = 20
) (
  input logic clk,
  input logic rst,
  uart_packet_receiver_if.slave bus
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(PACKET_SIZE + 1);
  localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IW = $clog2(TO + 1);
  localparam int PW = 8 * PACKET_SIZE;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic rx_meta, rxs, armed;
  logic [TW-1:0] timer;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic [BW-1:0] byte_idx;
  logic [IW-1:0] idle_cnt;
  logic [PW-1:0] assembly, asm_next, packet_r;
  logic valid_r, fe_r, to_r;
  logic bit_end;
  assign bit_end = timer == TW'(CLKS_PER_BIT - 1);
  always_comb begin
    asm_next = assembly;
    asm_next[PW - 8 - 8*int'(byte_idx) +: 8] = shift;
  end
  // armed drops after a bad stop bit so the still-low line is not taken as a new start
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs <= 1'b1;
      armed <= 1'b1;
      state <= IDLE;
      timer <= '0;
      bit_idx <= '0;
      shift <= '0;
      byte_idx <= '0;
      idle_cnt <= '0;
      assembly <= '0;
      packet_r <= '0;
      valid_r <= 1'b0;
      fe_r <= 1'b0;
      to_r <= 1'b0;
    end else begin
      rx_meta <= bus.rxd;
      rxs <= rx_meta;
      valid_r <= 1'b0;
      fe_r <= 1'b0;
      to_r <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (!armed) armed <= rxs;
          else if (!rxs) begin
            state <= START;
            idle_cnt <= '0;
          end else if (byte_idx != '0) begin
            if (idle_cnt == IW'(TO - 1)) begin
              to_r <= 1'b1;
              byte_idx <= '0;
              idle_cnt <= '0;
            end else idle_cnt <= idle_cnt + 1'b1;
          end
        end
        START: begin
          if (timer == TW'(CLKS_PER_BIT/2 - 1)) begin
            timer <= '0;
            if (!rxs) begin
              state <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              fe_r <= 1'b1;
              byte_idx <= '0;
            end
          end else timer <= timer + 1'b1;
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            shift <= {rxs, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else timer <= timer + 1'b1;
        end
        STOP: begin
          if (bit_end) begin
            timer <= '0;
            state <= IDLE;
            if (rxs) begin
              if (byte_idx == BW'(PACKET_SIZE - 1)) begin
                packet_r <= asm_next;
                valid_r <= 1'b1;
                byte_idx <= '0;
              end else begin
                assembly <= asm_next;
                byte_idx <= byte_idx + 1'b1;
              end
            end else begin
              fe_r <= 1'b1;
              byte_idx <= '0;
              armed <= 1'b0;
            end
          end else timer <= timer + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.packet = packet_r;
  assign bus.valid = valid_r;
  assign bus.frame_err = fe_r;
  assign bus.timeout = to_r;
  assign bus.busy = (state != IDLE) || (byte_idx != '0);
endmodule

// File: tb/tb_uart_packet_receiver.sv
// tb_uart_packet_receiver: directed tests of the UART packet receiver with 8 clocks per bit
module tb_uart_packet_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int valid_cnt = 0, fe_cnt = 0, to_cnt = 0, busy_bad = 0, dbl = 0, unstable = 0, coinc = 0;
  int fe_cyc = 0, to_cyc = 0;
  int vcycs[$];
  logic [15:0] pkts[$];
  logic [15:0] prev_pkt = '0;
  logic prev_valid = 1'b0;
  uart_packet_receiver_if #(.PACKET_SIZE(2)) bus();
  uart_packet_receiver #(.CLKS_PER_BIT(8), .PACKET_SIZE(2), .TIMEOUT_BITS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.valid) begin
      valid_cnt++;
      pkts.push_back(bus.packet);
      vcycs.push_back(cyc);
      if (bus.busy) busy_bad++;
      if (prev_valid) dbl++;
    end
    if (bus.frame_err) begin
      fe_cnt++;
      fe_cyc = cyc;
      if (bus.valid) coinc++;
    end
    if (bus.timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (bus.packet !== prev_pkt && !bus.valid) unstable++;
    prev_pkt = bus.packet;
    prev_valid = bus.valid;
  end
  // called on a falling edge; returns on the falling edge that ends the stop bit
  task automatic send_byte(input logic [7:0] b, input logic stop_val = 1'b1);
    logic [9:0] bits;
    bits = {stop_val, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rxd = bits[i];
      repeat (8) @(negedge clk);
    end
  endtask
  task automatic test_reset;
    bus.rxd = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (bus.packet !== 16'h0) begin failed++; $display("FAIL reset_packet: got %h exp 0000", bus.packet); end
    tests++; if (bus.valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b exp 0", bus.valid); end
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    tests++; if (bus.frame_err !== 1'b0) begin failed++; $display("FAIL reset_frame_err: got %b exp 0", bus.frame_err); end
    tests++; if (bus.timeout !== 1'b0) begin failed++; $display("FAIL reset_timeout: got %b exp 0", bus.timeout); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_timeout;
    int v0, f0, t0, s;
    v0 = valid_cnt; f0 = fe_cnt; t0 = to_cnt; s = cyc;
    send_byte(8'h61);
    tests++; if (bus.busy !== 1'b1) begin failed++; $display("FAIL to_busy_partial: got %b exp 1", bus.busy); end
    tests++; if (to_cnt - t0 !== 0) begin failed++; $display("FAIL to_early: got %0d pulses exp 0", to_cnt - t0); end
    repeat (60) @(negedge clk);
    tests++; if (to_cnt - t0 !== 1) begin failed++; $display("FAIL to_count: got %0d exp 1", to_cnt - t0); end
    tests++; if (to_cyc - s !== 111) begin failed++; $display("FAIL to_time: got %0d exp 111", to_cyc - s); end
    tests++; if (valid_cnt - v0 !== 0) begin failed++; $display("FAIL to_valid: got %0d exp 0", valid_cnt - v0); end
    tests++; if (fe_cnt - f0 !== 0) begin failed++; $display("FAIL to_frame_err: got %0d exp 0", fe_cnt - f0); end
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL to_busy_after: got %b exp 0", bus.busy); end
    tests++; if (bus.packet !== 16'h0) begin failed++; $display("FAIL to_packet: got %h exp 0000", bus.packet); end
  endtask
  task automatic test_back_to_back;
    int v0, f0, t0, b0, s;
    v0 = valid_cnt; f0 = fe_cnt; t0 = to_cnt; b0 = busy_bad; s = cyc;
    send_byte(8'h61);
    send_byte(8'h62);
    repeat (10) @(negedge clk);
    tests++; if (valid_cnt - v0 !== 1) begin failed++; $display("FAIL b2b_valid_count: got %0d exp 1", valid_cnt - v0); end
    tests++; if (bus.packet !== 16'h6162) begin failed++; $display("FAIL b2b_packet: got %h exp 6162", bus.packet); end
    tests++; if (vcycs[vcycs.size()-1] - s !== 159) begin failed++; $display("FAIL b2b_valid_time: got %0d exp 159", vcycs[vcycs.size()-1] - s); end
    tests++; if (busy_bad - b0 !== 0) begin failed++; $display("FAIL b2b_busy_at_valid: got %0d exp 0", busy_bad - b0); end
    tests++; if (fe_cnt - f0 !== 0) begin failed++; $display("FAIL b2b_frame_err: got %0d exp 0", fe_cnt - f0); end
    tests++; if (to_cnt - t0 !== 0) begin failed++; $display("FAIL b2b_timeout: got %0d exp 0", to_cnt - t0); end
  endtask
  task automatic test_frame_err;
    int v0, f0, t0, s;
    v0 = valid_cnt; f0 = fe_cnt; t0 = to_cnt; s = cyc;
    send_byte(8'h55, 1'b0);
    bus.rxd = 1'b1;
    tests++; if (fe_cnt - f0 !== 1) begin failed++; $display("FAIL fe_count: got %0d exp 1", fe_cnt - f0); end
    tests++; if (fe_cyc - s !== 79) begin failed++; $display("FAIL fe_time: got %0d exp 79", fe_cyc - s); end
    repeat (16) @(negedge clk);
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (10) @(negedge clk);
    tests++; if (fe_cnt - f0 !== 1) begin failed++; $display("FAIL fe_count_after: got %0d exp 1", fe_cnt - f0); end
    tests++; if (valid_cnt - v0 !== 1) begin failed++; $display("FAIL fe_valid_count: got %0d exp 1", valid_cnt - v0); end
    tests++; if (bus.packet !== 16'h1234) begin failed++; $display("FAIL fe_packet: got %h exp 1234", bus.packet); end
    tests++; if (to_cnt - t0 !== 0) begin failed++; $display("FAIL fe_timeout: got %0d exp 0", to_cnt - t0); end
  endtask
  task automatic test_false_start;
    int v0, f0, s;
    v0 = valid_cnt; f0 = fe_cnt; s = cyc;
    bus.rxd = 1'b0;
    repeat (2) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (20) @(negedge clk);
    tests++; if (fe_cnt - f0 !== 1) begin failed++; $display("FAIL fs_count: got %0d exp 1", fe_cnt - f0); end
    tests++; if (fe_cyc - s !== 7) begin failed++; $display("FAIL fs_time: got %0d exp 7", fe_cyc - s); end
    tests++; if (valid_cnt - v0 !== 0) begin failed++; $display("FAIL fs_valid: got %0d exp 0", valid_cnt - v0); end
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL fs_busy: got %b exp 0", bus.busy); end
    tests++; if (bus.packet !== 16'h1234) begin failed++; $display("FAIL fs_packet: got %h exp 1234", bus.packet); end
  endtask
  task automatic test_reset_mid_packet;
    int v0, f0, t0;
    v0 = valid_cnt; f0 = fe_cnt; t0 = to_cnt;
    send_byte(8'h61);
    bus.rxd = 1'b0;
    repeat (8) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (bus.packet !== 16'h0) begin failed++; $display("FAIL rm_packet: got %h exp 0000", bus.packet); end
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL rm_busy: got %b exp 0", bus.busy); end
    tests++; if ({bus.valid, bus.frame_err, bus.timeout} !== 3'b000) begin failed++; $display("FAIL rm_strobes: got %b exp 000", {bus.valid, bus.frame_err, bus.timeout}); end
    repeat (4) @(negedge clk);
    send_byte(8'hAA);
    send_byte(8'h0F);
    repeat (10) @(negedge clk);
    tests++; if (valid_cnt - v0 !== 1) begin failed++; $display("FAIL rm_valid_count: got %0d exp 1", valid_cnt - v0); end
    tests++; if (bus.packet !== 16'hAA0F) begin failed++; $display("FAIL rm_packet_after: got %h exp aa0f", bus.packet); end
    tests++; if (fe_cnt - f0 + to_cnt - t0 !== 0) begin failed++; $display("FAIL rm_errors: got %0d exp 0", fe_cnt - f0 + to_cnt - t0); end
  endtask
  task automatic test_four_bytes;
    int v0, u0, d0, c0, n;
    v0 = valid_cnt; u0 = unstable; d0 = dbl; c0 = coinc;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    repeat (10) @(negedge clk);
    n = pkts.size();
    tests++; if (valid_cnt - v0 !== 2) begin failed++; $display("FAIL fb_valid_count: got %0d exp 2", valid_cnt - v0); end
    tests++; if (pkts[n-2] !== 16'h0102) begin failed++; $display("FAIL fb_packet0: got %h exp 0102", pkts[n-2]); end
    tests++; if (pkts[n-1] !== 16'h0304) begin failed++; $display("FAIL fb_packet1: got %h exp 0304", pkts[n-1]); end
    tests++; if (vcycs[n-1] - vcycs[n-2] !== 160) begin failed++; $display("FAIL fb_spacing: got %0d exp 160", vcycs[n-1] - vcycs[n-2]); end
    tests++; if (unstable - u0 !== 0) begin failed++; $display("FAIL fb_packet_stable: got %0d changes exp 0", unstable - u0); end
    tests++; if (dbl - d0 !== 0) begin failed++; $display("FAIL fb_valid_width: got %0d long pulses exp 0", dbl - d0); end
    tests++; if (coinc - c0 !== 0) begin failed++; $display("FAIL fb_valid_fe_coincide: got %0d exp 0", coinc - c0); end
  endtask
  initial begin
    bus.rxd = 1'b1;
    test_reset;
    test_timeout;
    test_back_to_back;
    test_frame_err;
    test_false_start;
    test_reset_mid_packet;
    test_four_bytes;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
